// File: rtl/refemv_mem.sv
// Native-bus memory responder for the refemv core: word RAM, LED/cycle-counter I/O page,
// and programmable read/write wait states driving mem_rbusy/mem_wbusy.
module refemv_mem #(
  parameter int ADDR_WIDTH = 10,
  parameter int READ_WAIT  = 0,
  parameter int WRITE_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_rstrb,
  input  logic [3:0]  mem_wmask,
  output logic [31:0] mem_rdata,
  output logic        mem_rbusy,
  output logic        mem_wbusy,
  output logic [7:0]  io_leds
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {R_IDLE, R_WAIT} rstate_t;
  typedef enum logic {W_IDLE, W_WAIT} wstate_t;

  logic [31:0] ram [DEPTH];
  logic [31:0] led_q;
  logic [31:0] cycle_q;
  logic [31:0] raddr_q;
  logic [3:0]  rcount_q;
  logic [3:0]  wcount_q;
  rstate_t     rstate;
  wstate_t     wstate;

  logic [31:0] rd_addr;
  logic [31:0] rd_value;
  logic        wr_accept;
  logic        wr_ram;
  logic        wr_led;
  logic        unused_addr_bits;

  // A deferred read captures from the latched address, an immediate one from the bus.
  assign rd_addr = (rstate == R_IDLE) ? mem_addr : raddr_q;

  always_comb begin
    rd_value = 32'd0;
    if (rd_addr[22]) begin
      case (rd_addr[3:2])
        2'd1:    rd_value = led_q;
        2'd2:    rd_value = cycle_q;
        default: rd_value = 32'd0;
      endcase
    end else begin
      rd_value = ram[rd_addr[ADDR_WIDTH+1:2]];
    end
  end

  assign wr_accept = (|mem_wmask) && (wstate == W_IDLE);
  assign wr_ram    = wr_accept && !mem_addr[22];
  assign wr_led    = wr_accept && mem_addr[22] && (mem_addr[3:2] == 2'd1);
  assign io_leds   = led_q[7:0];

  assign unused_addr_bits = ^{rd_addr, mem_addr};

  // RAM contents survive reset; only the write is suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && wr_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wmask[i]) ram[mem_addr[ADDR_WIDTH+1:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= 32'd0;
      cycle_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (wr_led) begin
        for (int i = 0; i < 4; i++) begin
          if (mem_wmask[i]) led_q[8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate    <= R_IDLE;
      rcount_q  <= 4'd0;
      raddr_q   <= 32'd0;
      mem_rdata <= 32'd0;
      mem_rbusy <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (mem_rstrb) begin
            if (READ_WAIT == 0) begin
              mem_rdata <= rd_value;
            end else begin
              raddr_q   <= mem_addr;
              rcount_q  <= 4'(READ_WAIT);
              mem_rbusy <= 1'b1;
              rstate    <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          rcount_q <= rcount_q - 4'd1;
          if (rcount_q == 4'd1) begin
            mem_rdata <= rd_value;
            mem_rbusy <= 1'b0;
            rstate    <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate    <= W_IDLE;
      wcount_q  <= 4'd0;
      mem_wbusy <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if ((|mem_wmask) && (WRITE_WAIT != 0)) begin
            wcount_q  <= 4'(WRITE_WAIT);
            mem_wbusy <= 1'b1;
            wstate    <= W_WAIT;
          end
        end
        W_WAIT: begin
          wcount_q <= wcount_q - 4'd1;
          if (wcount_q == 4'd1) begin
            mem_wbusy <= 1'b0;
            wstate    <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

endmodule
